// File: rtl/dual_input_conditioner.sv
// Two-channel input front end: synchronises two asynchronous raw inputs, debounces
// each with a stability counter, and emits edge strobes plus a saturating glitch count.
module dual_input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT      = 4,
  parameter int GW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in1_raw,
  input  logic          in2_raw,
  input  logic          en,
  input  logic          clr_glitch,
  output logic          out1,
  output logic          out2,
  output logic          rise1,
  output logic          fall1,
  output logic          rise2,
  output logic          fall2,
  output logic          both_chg,
  output logic [GW-1:0] glitch_cnt
);

  localparam logic [7:0]  DC_LAST    = 8'(DB_CNT - 1);
  localparam logic [GW:0] GLITCH_MAX = {1'b0, {GW{1'b1}}};

  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [1:0]             s;

  logic [7:0]    dc_q [2];
  logic [7:0]    dc_d [2];
  logic [1:0]    out_q, out_d;
  logic [1:0]    rise_q, rise_d;
  logic [1:0]    fall_q, fall_d;
  logic          both_q, both_d;
  logic [1:0]    reject;
  logic [GW-1:0] glitch_q, glitch_d;
  logic [GW:0]   glitch_sum;

  assign raw = {in2_raw, in1_raw};
  assign s   = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    dc_d   = dc_q;
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    reject = '0;
    for (int k = 0; k < 2; k++) begin
      if (!en) begin
        dc_d[k] = '0;
      end else if (s[k] != out_q[k]) begin
        if (dc_q[k] == DC_LAST) begin
          out_d[k]  = s[k];
          dc_d[k]   = '0;
          rise_d[k] = s[k];
          fall_d[k] = ~s[k];
        end else begin
          dc_d[k] = dc_q[k] + 8'd1;
        end
      end else begin
        dc_d[k]   = '0;
        reject[k] = (dc_q[k] != 8'd0);
      end
    end
    both_d = (rise_d[0] | fall_d[0]) & (rise_d[1] | fall_d[1]);

    // Sum one bit wider than the counter so saturation is detected, not wrapped.
    glitch_sum = {1'b0, glitch_q} + (GW+1)'(reject[0]) + (GW+1)'(reject[1]);
    if (clr_glitch)
      glitch_d = '0;
    else if (glitch_sum > GLITCH_MAX)
      glitch_d = GLITCH_MAX[GW-1:0];
    else
      glitch_d = glitch_sum[GW-1:0];
  end

  // NOTE: all state, including the small counter arrays, is reset so a reset mid-debounce
  // discards partial counts; state updates use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        sync_q[k] <= '0;
        dc_q[k]   <= '0;
      end
      out_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      both_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], raw[k]};
        dc_q[k]   <= dc_d[k];
      end
      out_q    <= out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      both_q   <= both_d;
      glitch_q <= glitch_d;
    end
  end

  assign out1       = out_q[0];
  assign out2       = out_q[1];
  assign rise1      = rise_q[0];
  assign fall1      = fall_q[0];
  assign rise2      = rise_q[1];
  assign fall2      = fall_q[1];
  assign both_chg   = both_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_dual_input_conditioner.sv
// Directed bench for dual_input_conditioner at default parameters (latency 6, DB_CNT 4).
module tb_dual_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       in1_raw, in2_raw, en, clr_glitch;
  logic       out1, out2, rise1, fall1, rise2, fall2, both_chg;
  logic [7:0] glitch_cnt;

  int total = 0;
  int bad   = 0;
  logic [6:0] activity;

  dual_input_conditioner dut (
    .clk        (clk),
    .rst        (rst),
    .in1_raw    (in1_raw),
    .in2_raw    (in2_raw),
    .en         (en),
    .clr_glitch (clr_glitch),
    .out1       (out1),
    .out2       (out2),
    .rise1      (rise1),
    .fall1      (fall1),
    .rise2      (rise2),
    .fall2      (fall2),
    .both_chg   (both_chg),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      activity |= {out1, out2, rise1, fall1, rise2, fall2, both_chg};
    end
  endtask

  // Two-cycle raw pulse followed by enough quiet cycles for the reject edge to pass.
  task automatic pulse(input logic p1, input logic p2);
    in1_raw = p1;
    in2_raw = p2;
    tick(2);
    in1_raw = 1'b0;
    in2_raw = 1'b0;
    tick(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b1; clr_glitch = 1'b0;
    in1_raw = 1'b1; in2_raw = 1'b1;
    activity = '0;
    tick(3);
    check("reset_outs", {25'd0, out1, out2, rise1, fall1, rise2, fall2, both_chg}, 32'd0);
    check("reset_glitch", 32'(glitch_cnt), 32'd0);

    // Release with both inputs high: both outputs update together on edge 6.
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("startup_early", {30'd0, out1, out2}, 32'd0);
    end
    tick();
    check("startup_edge6", {25'd0, out1, out2, rise1, rise2, both_chg, fall1, fall2}, 32'b1111100);
    tick();
    check("startup_after", {25'd0, out1, out2, rise1, rise2, both_chg, fall1, fall2}, 32'b1100000);

    // Channel 1 falls alone.
    in1_raw = 1'b0;
    tick(5);
    check("fall1_edge5", 32'(out1), 32'd1);
    tick();
    check("fall1_edge6", {28'd0, out1, fall1, rise1, both_chg}, 32'b0100);
    tick();
    check("fall1_after", {30'd0, out1, fall1}, 32'd0);

    in2_raw = 1'b0;
    tick(6);
    check("fall2_edge6", {29'd0, out2, fall2, both_chg}, 32'b010);
    tick(2);

    // Channel 1 rises alone.
    in1_raw = 1'b1;
    tick(5);
    check("rise1_edge5", 32'(out1), 32'd0);
    tick();
    check("rise1_edge6", {28'd0, out1, rise1, fall1, both_chg}, 32'b1100);
    tick();
    check("rise1_after", {30'd0, out1, rise1}, 32'b10);
    in1_raw = 1'b0;
    tick(8);
    check("back_low", {30'd0, out1, out2}, 32'd0);

    // Short pulses are rejected and counted.
    activity = '0;
    pulse(1'b0, 1'b1);
    check("glitch2_quiet", 32'(activity), 32'd0);
    check("glitch2_count", 32'(glitch_cnt), 32'd1);
    pulse(1'b1, 1'b1);
    check("glitch_dual_quiet", 32'(activity), 32'd0);
    check("glitch_dual_count", 32'(glitch_cnt), 32'd3);

    clr_glitch = 1'b1;
    tick();
    clr_glitch = 1'b0;
    check("clr_glitch", 32'(glitch_cnt), 32'd0);

    // Saturation: 127 dual glitches reach 254, one more dual pair stops at 255.
    for (int i = 0; i < 127; i++) pulse(1'b1, 1'b1);
    check("glitch_254", 32'(glitch_cnt), 32'd254);
    pulse(1'b1, 1'b1);
    check("glitch_sat_dual", 32'(glitch_cnt), 32'd255);
    pulse(1'b1, 1'b0);
    check("glitch_sat_hold", 32'(glitch_cnt), 32'd255);

    // Clear on the very edge a glitch is rejected (edge 5 of the pulse) wins.
    in1_raw = 1'b1;
    tick(2);
    in1_raw = 1'b0;
    tick(2);
    clr_glitch = 1'b1;
    tick();
    clr_glitch = 1'b0;
    check("clr_priority", 32'(glitch_cnt), 32'd0);
    tick();
    pulse(1'b0, 1'b1);
    check("count_after_clr", 32'(glitch_cnt), 32'd1);

    // Disabled: output holds, no strobes, no glitches; re-enable restarts the count.
    en = 1'b0;
    in1_raw = 1'b1;
    activity = '0;
    tick(20);
    check("en0_hold", 32'(activity), 32'd0);
    check("en0_glitch", 32'(glitch_cnt), 32'd1);
    en = 1'b1;
    tick(3);
    check("reen_edge3", 32'(out1), 32'd0);
    tick();
    check("reen_edge4", {30'd0, out1, rise1}, 32'b11);

    // Reset in the middle of a channel 1 debounce (counter at 3).
    in1_raw = 1'b0;
    tick(8);
    in2_raw = 1'b1;
    tick(8);
    check("pre_rst_levels", {30'd0, out1, out2}, 32'b01);
    in1_raw = 1'b1;
    tick(5);
    rst = 1'b0;
    #1;
    check("rst_async_outs", {25'd0, out1, out2, rise1, fall1, rise2, fall2, both_chg}, 32'd0);
    check("rst_async_glitch", 32'(glitch_cnt), 32'd0);
    tick(2);
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("post_rst_early", {27'd0, out1, out2, rise1, rise2, both_chg}, 32'd0);
    end
    tick();
    check("post_rst_edge6", {27'd0, out1, rise1, out2, rise2, both_chg}, 32'b11111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
